// File: rtl/emaxi_bresp.sv
// -----------------------------------------------------------------------------
// emaxi_bresp
//   Write-response stage of the AXI-EMesh bridge. Snoops the AW and W
//   handshakes issued by the emesh-to-AXI write translator, tracks the number
//   of outstanding address and data bursts, keeps the issued AWIDs in an
//   in-order FIFO and consumes the AXI B channel. Responses are checked for
//   ID order and for SLVERR/DECERR. A throttle is raised toward the translator
//   when either outstanding count reaches MAX_OUT.
//
// Ports
//   clk, rstn        clock, asynchronous active-low reset
//   m_axi_aw*        snooped AW handshake and AWID
//   m_axi_w*         snooped W handshake and WLAST
//   m_axi_b*         B channel (bready is driven here)
//   err_clr          clears sticky flags and the error counter
//   wr_throttle      no new AW/W burst may start while high
//   idle             no outstanding address or data
//   err_valid        one-cycle pulse per bad response
//   err_resp/err_id  BRESP/BID of the last bad response
//   err_cnt          saturating count of bad responses
//   id_mismatch      sticky: BID differed from the expected in-order ID
//   proto_err        sticky: overflow of a count or B while idle
// -----------------------------------------------------------------------------
module emaxi_bresp #(
    parameter int ID_W     = 4,
    parameter int MAX_OUT  = 8,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [ID_W-1:0]     m_axi_awid,
    input  logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    input  logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic                m_axi_wlast,
    input  logic [ID_W-1:0]     m_axi_bid,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    input  logic                err_clr,
    output logic                wr_throttle,
    output logic                idle,
    output logic                err_valid,
    output logic [1:0]          err_resp,
    output logic [ID_W-1:0]     err_id,
    output logic [ERRCNT_W-1:0] err_cnt,
    output logic                id_mismatch,
    output logic                proto_err
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

    function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
        return (&v) ? v : v + ERRCNT_W'(1);
    endfunction

    logic [CNT_W-1:0]    r_aw_cnt;
    logic [CNT_W-1:0]    r_wl_cnt;
    logic [PTR_W-1:0]    r_wptr;
    logic [PTR_W-1:0]    r_rptr;
    logic [ID_W-1:0]     r_fifo [MAX_OUT];
    logic                r_bv_idle;
    logic                r_err_valid;
    logic [1:0]          r_err_resp;
    logic [ID_W-1:0]     r_err_id;
    logic [ERRCNT_W-1:0] r_err_cnt;
    logic                r_id_mis;
    logic                r_proto;

    logic            w_aw_fire;
    logic            w_wl_fire;
    logic            w_b_fire;
    logic            w_aw_full;
    logic            w_wl_full;
    logic            w_aw_push;
    logic            w_wl_inc;
    logic            w_idle;
    logic            w_bready;
    logic [ID_W-1:0] w_head;
    logic            w_id_mis;
    logic            w_bad;
    logic            w_proto;

    assign w_aw_fire = m_axi_awvalid & m_axi_awready;
    assign w_wl_fire = m_axi_wvalid & m_axi_wready & m_axi_wlast;
    assign w_aw_full = (r_aw_cnt == CNT_MAX);
    assign w_wl_full = (r_wl_cnt == CNT_MAX);
    // An AW or W-last arriving at the limit is a protocol violation; it is
    // not counted and the AWID is not pushed.
    assign w_aw_push = w_aw_fire & ~w_aw_full;
    assign w_wl_inc  = w_wl_fire & ~w_wl_full;

    assign w_idle    = (r_aw_cnt == '0) & (r_wl_cnt == '0);
    // bready comes only from registered counts so it never depends on bvalid.
    assign w_bready  = (r_aw_cnt != '0) & (r_wl_cnt != '0);
    assign w_b_fire  = m_axi_bvalid & w_bready;

    assign w_head    = r_fifo[r_rptr];
    assign w_id_mis  = w_b_fire & (m_axi_bid != w_head);
    assign w_bad     = w_b_fire & m_axi_bresp[1];
    // B valid while idle is only flagged once it has persisted for two cycles.
    assign w_proto   = (w_aw_fire & w_aw_full) | (w_wl_fire & w_wl_full) |
                       (m_axi_bvalid & w_idle & r_bv_idle);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_aw_cnt <= '0;
            r_wl_cnt <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
        end else begin
            if (w_aw_push && !w_b_fire)
                r_aw_cnt <= r_aw_cnt + CNT_W'(1);
            else if (!w_aw_push && w_b_fire)
                r_aw_cnt <= r_aw_cnt - CNT_W'(1);

            if (w_wl_inc && !w_b_fire)
                r_wl_cnt <= r_wl_cnt + CNT_W'(1);
            else if (!w_wl_inc && w_b_fire)
                r_wl_cnt <= r_wl_cnt - CNT_W'(1);

            if (w_aw_push)
                r_wptr <= r_wptr + PTR_W'(1);
            if (w_b_fire)
                r_rptr <= r_rptr + PTR_W'(1);
        end
    end

    // ID storage needs no reset: only entries between the pointers are read.
    always_ff @(posedge clk) begin
        if (w_aw_push)
            r_fifo[r_wptr] <= m_axi_awid;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bv_idle   <= 1'b0;
            r_err_valid <= 1'b0;
            r_err_resp  <= '0;
            r_err_id    <= '0;
            r_err_cnt   <= '0;
            r_id_mis    <= 1'b0;
            r_proto     <= 1'b0;
        end else begin
            r_bv_idle   <= m_axi_bvalid & w_idle;
            r_err_valid <= w_bad;

            if (w_bad) begin
                r_err_resp <= m_axi_bresp;
                r_err_id   <= m_axi_bid;
            end

            // A new error in the same cycle as a clear restarts the count at 1.
            if (w_bad)
                r_err_cnt <= err_clr ? ERRCNT_W'(1) : sat_inc(r_err_cnt);
            else if (err_clr)
                r_err_cnt <= '0;

            if (w_id_mis)
                r_id_mis <= 1'b1;
            else if (err_clr)
                r_id_mis <= 1'b0;

            if (w_proto)
                r_proto <= 1'b1;
            else if (err_clr)
                r_proto <= 1'b0;
        end
    end

    assign m_axi_bready = w_bready;
    assign wr_throttle  = w_aw_full | w_wl_full;
    assign idle         = w_idle;
    assign err_valid    = r_err_valid;
    assign err_resp     = r_err_resp;
    assign err_id       = r_err_id;
    assign err_cnt      = r_err_cnt;
    assign id_mismatch  = r_id_mis;
    assign proto_err    = r_proto;

endmodule

// File: tb/tb_emaxi_bresp.sv
// -----------------------------------------------------------------------------
// tb_emaxi_bresp
//   Directed bench for emaxi_bresp. Inputs change 1 time unit after the rising
//   edge; outputs are sampled at the same point, i.e. reflecting the edge just
//   passed. Bad responses are queued as expected error events when driven and
//   popped by a monitor when err_valid is seen.
// -----------------------------------------------------------------------------
module tb_emaxi_bresp;

    localparam int ID_W     = 4;
    localparam int MAX_OUT  = 8;
    localparam int ERRCNT_W = 8;

    logic                clk;
    logic                rstn;
    logic [ID_W-1:0]     awid;
    logic                awvalid, awready;
    logic                wvalid, wready, wlast;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic                err_clr;
    logic                wr_throttle;
    logic                idle;
    logic                err_valid;
    logic [1:0]          err_resp;
    logic [ID_W-1:0]     err_id;
    logic [ERRCNT_W-1:0] err_cnt;
    logic                id_mismatch;
    logic                proto_err;

    typedef struct packed {
        logic [1:0]      resp;
        logic [ID_W-1:0] id;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    emaxi_bresp #(.ID_W(ID_W), .MAX_OUT(MAX_OUT), .ERRCNT_W(ERRCNT_W)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .m_axi_awid    (awid),
        .m_axi_awvalid (awvalid),
        .m_axi_awready (awready),
        .m_axi_wvalid  (wvalid),
        .m_axi_wready  (wready),
        .m_axi_wlast   (wlast),
        .m_axi_bid     (bid),
        .m_axi_bresp   (bresp),
        .m_axi_bvalid  (bvalid),
        .m_axi_bready  (bready),
        .err_clr       (err_clr),
        .wr_throttle   (wr_throttle),
        .idle          (idle),
        .err_valid     (err_valid),
        .err_resp      (err_resp),
        .err_id        (err_id),
        .err_cnt       (err_cnt),
        .id_mismatch   (id_mismatch),
        .proto_err     (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        awvalid = 1'b0; awready = 1'b0;
        wvalid  = 1'b0; wready  = 1'b0; wlast = 1'b0;
        bvalid  = 1'b0; err_clr = 1'b0;
    endtask

    task automatic drv_aw(input logic [ID_W-1:0] id);
        awid = id; awvalid = 1'b1; awready = 1'b1;
    endtask

    task automatic drv_w();
        wvalid = 1'b1; wready = 1'b1; wlast = 1'b1;
    endtask

    task automatic drv_b(input logic [ID_W-1:0] id, input logic [1:0] r);
        bid = id; bresp = r; bvalid = 1'b1;
        if (r[1]) exp_q.push_back('{resp: r, id: id});
    endtask

    // Error-event scoreboard monitor.
    always @(negedge clk) begin
        if (rstn && err_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_err_valid", 32'(err_valid), 32'd0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("sb_err_resp", 32'(err_resp), 32'(e.resp));
                chk("sb_err_id", 32'(err_id), 32'(e.id));
            end
        end
    end

    initial begin
        rstn = 1'b0;
        awid = '0; bid = '0; bresp = '0;
        quiet();
        tick(); tick();
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_bready", 32'(bready), 32'd0);
        chk("rst_throttle", 32'(wr_throttle), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_flags", {30'd0, id_mismatch, proto_err}, 32'd0);
        rstn = 1'b1;
        tick();

        // Single write
        drv_aw(4'd3);
        tick(); quiet();
        chk("single_bready_aw_only", 32'(bready), 32'd0);
        chk("single_idle_aw", 32'(idle), 32'd0);
        drv_w();
        tick(); quiet();
        chk("single_bready_both", 32'(bready), 32'd1);
        drv_b(4'd3, 2'b00);
        tick(); quiet();
        chk("single_idle_after_b", 32'(idle), 32'd1);
        chk("single_bready_after_b", 32'(bready), 32'd0);
        chk("single_err_cnt", 32'(err_cnt), 32'd0);
        chk("single_id_mis", 32'(id_mismatch), 32'd0);

        // Fill to limit
        for (int i = 0; i < MAX_OUT; i++) begin
            drv_aw(ID_W'(i)); drv_w();
            tick(); quiet();
            chk("fill_throttle", 32'(wr_throttle), (i == MAX_OUT - 1) ? 32'd1 : 32'd0);
        end
        drv_b(4'd0, 2'b00);
        tick(); quiet();
        chk("fill_throttle_drop", 32'(wr_throttle), 32'd0);
        chk("fill_bready", 32'(bready), 32'd1);
        for (int i = 1; i < MAX_OUT; i++) begin
            drv_b(ID_W'(i), 2'b00);
            tick(); quiet();
        end
        chk("fill_drained_idle", 32'(idle), 32'd1);
        chk("fill_id_mis", 32'(id_mismatch), 32'd0);
        chk("fill_proto", 32'(proto_err), 32'd0);

        // Simultaneous AW+W and B with two outstanding
        drv_aw(4'd10); drv_w(); tick(); quiet();
        drv_aw(4'd11); drv_w(); tick(); quiet();
        drv_aw(4'd12); drv_w(); drv_b(4'd10, 2'b00);
        tick(); quiet();
        chk("simul_bready", 32'(bready), 32'd1);
        chk("simul_idle", 32'(idle), 32'd0);
        drv_b(4'd11, 2'b00); tick(); quiet();
        chk("simul_one_left_bready", 32'(bready), 32'd1);
        drv_b(4'd12, 2'b00); tick(); quiet();
        chk("simul_drained_idle", 32'(idle), 32'd1);
        chk("simul_id_mis", 32'(id_mismatch), 32'd0);

        // Error responses
        drv_aw(4'd5); drv_w(); tick(); quiet();
        drv_b(4'd5, 2'b10); tick(); quiet();
        chk("err_valid_pulse", 32'(err_valid), 32'd1);
        chk("err_resp_slverr", 32'(err_resp), 32'd2);
        chk("err_id_5", 32'(err_id), 32'd5);
        chk("err_cnt_1", 32'(err_cnt), 32'd1);
        tick();
        chk("err_valid_one_cycle", 32'(err_valid), 32'd0);
        chk("err_resp_hold", 32'(err_resp), 32'd2);
        drv_aw(4'd6); drv_w(); tick(); quiet();
        drv_b(4'd6, 2'b11); tick(); quiet();
        chk("err_cnt_2", 32'(err_cnt), 32'd2);
        chk("err_resp_decerr", 32'(err_resp), 32'd3);
        drv_aw(4'd9); drv_w(); tick(); quiet();
        drv_b(4'd9, 2'b01); tick(); quiet();
        chk("exokay_no_err", 32'(err_valid), 32'd0);
        chk("exokay_cnt", 32'(err_cnt), 32'd2);
        chk("exokay_id_hold", 32'(err_id), 32'd6);

        // Order fault
        drv_aw(4'd1); drv_w(); tick(); quiet();
        drv_aw(4'd2); drv_w(); tick(); quiet();
        drv_b(4'd2, 2'b00); tick(); quiet();
        chk("order_id_mis", 32'(id_mismatch), 32'd1);
        drv_b(4'd2, 2'b00); tick(); quiet();
        chk("order_idle", 32'(idle), 32'd1);
        chk("order_proto_clean", 32'(proto_err), 32'd0);

        // B valid while idle
        bid = 4'd0; bresp = 2'b00; bvalid = 1'b1;
        tick();
        chk("bv_idle_1cyc", 32'(proto_err), 32'd0);
        tick(); quiet();
        chk("bv_idle_2cyc", 32'(proto_err), 32'd1);
        err_clr = 1'b1; tick(); quiet();
        chk("clr_id_mis", 32'(id_mismatch), 32'd0);
        chk("clr_proto", 32'(proto_err), 32'd0);
        chk("clr_err_cnt", 32'(err_cnt), 32'd0);

        // Clear and new error in the same cycle
        drv_aw(4'd7); drv_w(); tick(); quiet();
        drv_b(4'd7, 2'b10); err_clr = 1'b1; tick(); quiet();
        chk("clr_vs_err_cnt", 32'(err_cnt), 32'd1);

        // Overflow: ninth AW at the limit
        for (int i = 0; i < MAX_OUT; i++) begin
            drv_aw(ID_W'(i)); drv_w(); tick(); quiet();
        end
        chk("ovf_before", 32'(proto_err), 32'd0);
        drv_aw(4'd15); tick(); quiet();
        chk("ovf_proto", 32'(proto_err), 32'd1);
        chk("ovf_throttle", 32'(wr_throttle), 32'd1);
        for (int i = 0; i < MAX_OUT; i++) begin
            drv_b(ID_W'(i), 2'b00); tick(); quiet();
        end
        chk("ovf_drained_idle", 32'(idle), 32'd1);
        chk("ovf_no_mis", 32'(id_mismatch), 32'd0);

        // Mid-operation reset with four outstanding writes
        for (int i = 0; i < 4; i++) begin
            drv_aw(ID_W'(i + 4)); drv_w(); tick(); quiet();
        end
        chk("pre_rst_bready", 32'(bready), 32'd1);
        rstn = 1'b0;
        #1;
        chk("arst_bready", 32'(bready), 32'd0);
        chk("arst_throttle", 32'(wr_throttle), 32'd0);
        chk("arst_idle", 32'(idle), 32'd1);
        chk("arst_err_cnt", 32'(err_cnt), 32'd0);
        chk("arst_flags", {30'd0, id_mismatch, proto_err}, 32'd0);
        chk("arst_err_out", {26'd0, err_valid, err_resp, err_id[2:0]}, 32'd0);
        chk("arst_err_id", 32'(err_id), 32'd0);
        tick();
        rstn = 1'b1;
        tick();
        chk("post_rst_idle", 32'(idle), 32'd1);
        drv_aw(4'd13); drv_w(); tick(); quiet();
        drv_b(4'd13, 2'b00); tick(); quiet();
        chk("post_rst_id_mis", 32'(id_mismatch), 32'd0);
        chk("post_rst_idle2", 32'(idle), 32'd1);

        tick();
        chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
